// File: rtl/truth_table_probe.sv
// Characterizes an unknown 3-input combinational function by sweeping all
// eight input vectors and majority-voting three samples per vector.
module truth_table_probe #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned SAMPLES       = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] expected,
   input  logic       probe_out,
   output logic [2:0] probe_in,
   output logic       busy,
   output logic       done,
   output logic       valid,
   output logic [7:0] code,
   output logic       match
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam logic [7:0] SET_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [1:0] SMP_LAST = 2'(SAMPLES - 1);

   state_t     state, state_n;
   logic [2:0] vec, vec_n;
   logic [7:0] settle_cnt, settle_n;
   logic [1:0] samp_cnt, samp_n;
   logic [1:0] ones, ones_n;
   logic [1:0] ones_add;
   logic [7:0] work, work_n;
   logic [7:0] code_n;
   logic       valid_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         vec        <= 3'd0;
         settle_cnt <= 8'd0;
         samp_cnt   <= 2'd0;
         ones       <= 2'd0;
         work       <= 8'd0;
         code       <= 8'd0;
         valid      <= 1'b0;
      end else begin
         state      <= state_n;
         vec        <= vec_n;
         settle_cnt <= settle_n;
         samp_cnt   <= samp_n;
         ones       <= ones_n;
         work       <= work_n;
         code       <= code_n;
         valid      <= valid_n;
      end
   end

   always_comb begin
      state_n  = state;
      vec_n    = vec;
      settle_n = settle_cnt;
      samp_n   = samp_cnt;
      ones_n   = ones;
      work_n   = work;
      code_n   = code;
      valid_n  = valid;
      ones_add = ones + {1'b0, probe_out};
      unique case (state)
         IDLE: begin
            if (start) begin
               vec_n    = 3'd0;
               valid_n  = 1'b0;
               settle_n = 8'd0;
               samp_n   = 2'd0;
               ones_n   = 2'd0;
               work_n   = 8'd0;
               state_n  = SETTLE;
            end
         end
         SETTLE: begin
            if (abort) begin
               state_n  = IDLE;
               vec_n    = 3'd0;
               valid_n  = 1'b0;
               settle_n = 8'd0;
               samp_n   = 2'd0;
               ones_n   = 2'd0;
            end else if (settle_cnt == SET_LAST) begin
               settle_n = 8'd0;
               state_n  = SAMPLE;
            end else begin
               settle_n = settle_cnt + 8'd1;
            end
         end
         SAMPLE: begin
            if (abort) begin
               state_n  = IDLE;
               vec_n    = 3'd0;
               valid_n  = 1'b0;
               settle_n = 8'd0;
               samp_n   = 2'd0;
               ones_n   = 2'd0;
            end else if (samp_cnt == SMP_LAST) begin
               // vector 000 lands in the MSB
               work_n[3'd7 - vec] = (ones_add >= 2'd2);
               samp_n = 2'd0;
               ones_n = 2'd0;
               if (vec == 3'd7) begin
                  code_n  = work_n;
                  valid_n = 1'b1;
                  state_n = DONE;
               end else begin
                  vec_n   = vec + 3'd1;
                  state_n = SETTLE;
               end
            end else begin
               samp_n = samp_cnt + 2'd1;
               ones_n = ones_add;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
      endcase
   end

   assign probe_in = vec;
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
   assign match    = valid && (code == expected);

endmodule

// File: tb/tb_truth_table_probe.sv
// Bench for truth_table_probe: a behavioural function model feeds probe_out,
// expected codes go through a scoreboard queue and are popped on done.
module tb_truth_table_probe;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [7:0] expected;
   logic       probe_out;
   logic [2:0] probe_in;
   logic       busy;
   logic       done;
   logic       valid;
   logic [7:0] code;
   logic       match;

   logic       start2;
   logic       probe_out2;
   logic [2:0] probe_in2;
   logic       busy2;
   logic       done2;
   logic       valid2;
   logic [7:0] code2;
   logic       match2;

   logic [7:0] func;
   logic       inv;
   logic [7:0] sb[$];
   int         total;
   int         bad;

   truth_table_probe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .expected  (expected),
      .probe_out (probe_out),
      .probe_in  (probe_in),
      .busy      (busy),
      .done      (done),
      .valid     (valid),
      .code      (code),
      .match     (match)
   );

   truth_table_probe #(.SETTLE_CYCLES(1)) dut_fast (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start2),
      .abort     (1'b0),
      .expected  (8'h4F),
      .probe_out (probe_out2),
      .probe_in  (probe_in2),
      .busy      (busy2),
      .done      (done2),
      .valid     (valid2),
      .code      (code2),
      .match     (match2)
   );

   // function under test: vector v drives func[7-v]
   assign probe_out  = func[3'd7 - probe_in] ^ inv;
   assign probe_out2 = func[3'd7 - probe_in2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // start at edge 0; outputs observed on the negedge after each edge
   task automatic run(input int restart_e, input int abort_e,
                      input int rst_e, input int inv_a, input int inv_b,
                      output int done_e, output int busy_n,
                      output int done_n, output logic [7:0] got);
      done_e = -1;
      busy_n = 0;
      done_n = 0;
      got    = 8'hxx;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k < 200; k++) begin
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            done_e = k - 1;
            got    = code;
         end
         if (k - 1 == rst_e) begin
            rst_n = 1'b0;
            #1;
            break;
         end
         if (!busy) break;
         start = (k == restart_e);
         abort = (k == abort_e);
         inv   = (k == inv_a) || (k == inv_b);
         @(posedge clk);
         @(negedge clk);
      end
      start = 1'b0;
      abort = 1'b0;
      inv   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      total++;
      if (probe_in !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctl: probe_in=%0d busy=%b done=%b want 0 0 0",
                  probe_in, busy, done);
      end
      total++;
      if (valid !== 1'b0 || code !== 8'h00 || match !== 1'b0) begin
         bad++;
         $display("FAIL reset_res: valid=%b code=%h match=%b want 0 00 0",
                  valid, code, match);
      end
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL first_edge_start: busy=%b want 1", busy);
      end
      abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0;
      total++;
      if (busy !== 1'b0 || probe_in !== 3'd0 || valid !== 1'b0) begin
         bad++;
         $display("FAIL abort_settle: busy=%b probe_in=%0d valid=%b want 0 0 0",
                  busy, probe_in, valid);
      end
   endtask

   task automatic test_func();
      int de, bn, dn;
      logic [7:0] got, want;
      func     = 8'h4F;
      expected = 8'h4F;
      sb.push_back(8'h4F);
      run(0, 0, -1, 0, 0, de, bn, dn, got);
      want = sb.pop_front();
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL func_code: got %h want %h", got, want);
      end
      total++;
      if (de != 56 || dn != 1 || bn != 57) begin
         bad++;
         $display("FAIL func_timing: done_edge=%0d pulses=%0d busy=%0d want 56 1 57",
                  de, dn, bn);
      end
      total++;
      if (valid !== 1'b1 || match !== 1'b1) begin
         bad++;
         $display("FAIL func_match: valid=%b match=%b want 1 1", valid, match);
      end
      expected = 8'h4E;
      #1;
      total++;
      if (match !== 1'b0) begin
         bad++;
         $display("FAIL match_track: match=%b want 0", match);
      end
      expected = 8'h4F;
   endtask

   task automatic test_const();
      int de, bn, dn;
      logic [7:0] got, want;
      for (int i = 0; i < 2; i++) begin
         func = (i == 0) ? 8'h00 : 8'hFF;
         sb.push_back(func);
         run(0, 0, -1, 0, 0, de, bn, dn, got);
         want = sb.pop_front();
         total++;
         if (got !== want || bn != 57) begin
            bad++;
            $display("FAIL const_%0d: code=%h busy=%0d want %h 57",
                     i, got, bn, want);
         end
      end
   endtask

   task automatic test_glitch();
      int de, bn, dn;
      logic [7:0] got, want;
      func = 8'h4F;
      sb.push_back(8'h4F);
      run(0, 0, -1, 12, 0, de, bn, dn, got);
      want = sb.pop_front();
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL glitch_one: code=%h want %h", got, want);
      end
      sb.push_back(8'h0F);
      run(0, 0, -1, 12, 13, de, bn, dn, got);
      want = sb.pop_front();
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL glitch_two: code=%h want %h", got, want);
      end
   endtask

   task automatic test_back_to_back();
      int de, bn, dn;
      logic [7:0] got, want;
      func = 8'h4F;
      sb.push_back(8'h4F);
      run(24, 0, -1, 0, 0, de, bn, dn, got);
      want = sb.pop_front();
      total++;
      if (got !== want || de != 56 || dn != 1) begin
         bad++;
         $display("FAIL restart_ignored: code=%h edge=%0d pulses=%0d want %h 56 1",
                  got, de, dn, want);
      end
   endtask

   task automatic test_abort();
      int de, bn, dn;
      logic [7:0] got;
      func = 8'hFF;
      run(0, 41, -1, 0, 0, de, bn, dn, got);
      total++;
      if (bn != 41 || dn != 0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL abort_sample: busy_cycles=%0d pulses=%0d busy=%b want 41 0 0",
                  bn, dn, busy);
      end
      total++;
      if (probe_in !== 3'd0 || valid !== 1'b0 || code !== 8'h4F) begin
         bad++;
         $display("FAIL abort_state: probe_in=%0d valid=%b code=%h want 0 0 4f",
                  probe_in, valid, code);
      end
   endtask

   task automatic test_reset_mid();
      int de, bn, dn;
      logic [7:0] got, want;
      func = 8'h4F;
      run(0, 0, 44, 0, 0, de, bn, dn, got);
      total++;
      if (probe_in !== 3'd0 || busy !== 1'b0 || done !== 1'b0 ||
          valid !== 1'b0 || code !== 8'h00 || dn != 0) begin
         bad++;
         $display("FAIL reset_mid: probe_in=%0d busy=%b done=%b valid=%b code=%h want 0 0 0 0 00",
                  probe_in, busy, done, valid, code);
      end
      @(negedge clk);
      rst_n = 1'b1;
      sb.push_back(8'h4F);
      run(0, 0, -1, 0, 0, de, bn, dn, got);
      want = sb.pop_front();
      total++;
      if (got !== want || bn != 57 || de != 56) begin
         bad++;
         $display("FAIL after_reset_run: code=%h busy=%0d edge=%0d want %h 57 56",
                  got, bn, de, want);
      end
   endtask

   task automatic test_fast();
      int de;
      logic [7:0] got, want;
      de   = -1;
      got  = 8'hxx;
      func = 8'h4F;
      sb.push_back(8'h4F);
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start2 = 1'b0;
      for (int k = 1; k < 100; k++) begin
         if (k - 1 < 32) begin
            total++;
            if (probe_in2 !== 3'((k - 1) / 4)) begin
               bad++;
               $display("FAIL fast_step_e%0d: probe_in=%0d want %0d",
                        k - 1, probe_in2, (k - 1) / 4);
            end
         end
         if (done2) begin
            de  = k - 1;
            got = code2;
         end
         if (!busy2) break;
         @(posedge clk);
         @(negedge clk);
      end
      want = sb.pop_front();
      total++;
      if (got !== want || de != 32) begin
         bad++;
         $display("FAIL fast_run: code=%h edge=%0d want %h 32", got, de, want);
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      start2   = 1'b0;
      abort    = 1'b0;
      expected = 8'h4F;
      func     = 8'h4F;
      inv      = 1'b0;
      #12;
      test_reset();
      test_func();
      test_const();
      test_glitch();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_fast();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/truth_table_probe.md
TRUTH_TABLE_PROBE -- requirements
Module: truth_table_probe

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4, giving the cycles a drive vector is held before sampling (legal range 1..255).
REQ-002 The block SHALL have parameter SAMPLES, fixed at 3, giving the consecutive samples per vector used for majority vote.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request a full 8-vector characterization; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of a run in progress.
REQ-007 expected  input  8  reference function code for comparison.
REQ-008 probe_out  input  1  output of the 3-input logic function under test.
REQ-009 probe_in  output  3  drive vector to the function under test; probe_in[2]=in1, [1]=in2, [0]=in3.
REQ-010 busy  output  1  high in any state except IDLE.
REQ-011 done  output  1  one-cycle pulse when a run completes.
REQ-012 valid  output  1  code holds a completed result.
REQ-013 code  output  8  recovered function code.
REQ-014 match  output  1  valid AND (code == expected).

Function
REQ-015 The FSM SHALL have the states IDLE, SETTLE, SAMPLE and DONE.
REQ-016 In IDLE with start=1, the block SHALL set vec=0, probe_in=000, clear valid, clear the settle and sample counters, and enter SETTLE.
REQ-017 In SETTLE, the block SHALL hold probe_in=vec for exactly SETTLE_CYCLES edges, then enter SAMPLE.
REQ-018 In SAMPLE, the block SHALL register probe_out on 3 consecutive edges and count the ones.
REQ-019 The bit for each vector SHALL be 1 iff ones >= 2.
REQ-020 Bit mapping SHALL be code[7-vec] = voted bit, so vector 000 maps to the MSB and vector 111 to the LSB.
REQ-021 At the end of SAMPLE with vec<7, the block SHALL increment vec, update probe_in on the same edge, and re-enter SETTLE.
REQ-022 At the end of SAMPLE with vec==7, the block SHALL enter DONE.
REQ-023 The working code register SHALL be separate from the code output; code SHALL update only on entry to DONE.
REQ-024 DONE SHALL last exactly one cycle with done=1; valid SHALL be set to 1, then the FSM SHALL return to IDLE.
REQ-025 Latency: if start is sampled at edge 0, done SHALL be high for the single cycle following edge 8*(SETTLE_CYCLES+3), which is edge 56 for the default.
REQ-026 start in any non-IDLE state SHALL be ignored, and no restart SHALL occur.
REQ-027 start in the DONE cycle SHALL also be ignored.
REQ-028 abort=1 in SETTLE or SAMPLE SHALL take the FSM to IDLE on the next edge with probe_in=000 and valid=0; code SHALL be unchanged and no done pulse SHALL be produced.
REQ-029 abort SHALL take priority over the SETTLE and SAMPLE transitions on the same edge.
REQ-030 abort in IDLE or DONE SHALL have no effect.
REQ-031 match SHALL be combinational from valid, code and expected, and SHALL track changes to expected while valid=1.

Reset
REQ-032 rst_n=0 SHALL immediately force the FSM to IDLE, probe_in=000, busy=0, done=0, valid=0, code=8'h00 and all counters to 0.
REQ-033 Reset assertion mid-run SHALL discard partial results, with no done pulse.
REQ-034 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-035 DUT model of function 0x4F (outputs 0,1,0,0,1,1,1,1 for vectors 000..111), SETTLE_CYCLES=4, expected=8'h4F, start pulse -> done high only in the cycle after edge 56, code=8'h4F, valid=1, match=1; then expected=8'h4E -> match=0.
REQ-036 probe_out constant 0 -> code=8'h00; probe_out constant 1 -> code=8'hFF; busy is high for exactly 57 cycles in each run.
REQ-037 0x4F model with probe_out inverted for one SAMPLE cycle of vector 001 -> code still 8'h4F; inverted for two SAMPLE cycles of that vector -> code=8'h0F.
REQ-038 start re-pulsed while busy at vector 3 -> no restart, done at the original edge 56; abort during SAMPLE of vector 5 -> next edge IDLE, probe_in=000, valid=0, code keeps the previous result.
REQ-039 rst_n low during SETTLE of vector 6 -> outputs immediately at reset values; a subsequent start -> full 57-cycle run with a correct code.
REQ-040 SETTLE_CYCLES=1 with the 0x4F model -> done after edge 32, code=8'h4F; probe_in steps 000..111 in order, each held for 4 edges.
